pe_seq_ctrl_6: RTL and testbench
================================

Name: pe_seq_ctrl_6

Overview:
- Sequencer in front of the 6-MAC PE top.
- Loads the weight scratchpad through WGT_BEATS write beats, then streams sparse feature beats node by node (pe_x_we, pe_acc, pe_done).
- Throttles issue against outstanding PE results and tags each returned result with its node index.
- Sits between the feature/weight fetch streams and one PE_TOP_6 instance.

Parameters:
- MAC_DIM, 6, non-zero address slots per feature beat
- FEAT_WIDTH, 1, feature bit width
- WGT_WIDTH, 8, weight bit width
- SPAD_WIDTH, 64, scratchpad entries
- PE_OUT_WIDTH, 8, PE result width
- NUM_NODES, 20, maximum nodes per run
- MAX_OUTST, 2, maximum nodes issued but not yet returned by the PE (1..7)
- ISSUE_GAP, 1, minimum cycles between consecutive pe_x_we pulses (>=1)
- Derived constants (package):
  - ADDR_WIDTH = C_LOG_2(SPAD_WIDTH)
  - WGT_INDEX = C_LOG_2(WGT_WIDTH)
  - BUS_W = FEAT_WIDTH*SPAD_WIDTH
  - WGT_BEATS = SPAD_WIDTH*WGT_WIDTH/BUS_W = 8
  - NODE_W = C_LOG_2(NUM_NODES)+1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  run request; sampled in IDLE only
- num_nodes  in  NODE_W  nodes in this run; sampled with start
- w_valid  in  1  weight beat valid
- w_ready  out  1  weight beat accept
- w_data  in  BUS_W  8 packed weights
- s_valid  in  1  feature beat valid
- s_ready  out  1  feature beat accept
- s_data  in  BUS_W  feature vector
- s_addr  in  ADDR_WIDTH*MAC_DIM  non-zero addresses
- s_nnz  in  3  non-zero count (0..6)
- s_last  in  1  last beat of the current node
- pe_addr_bus  out  ADDR_WIDTH*MAC_DIM  to PE addr_bus
- pe_data_bus  out  BUS_W  to PE data_bus
- pe_non_zero_num  out  3  to PE
- pe_acc  out  1  to PE
- pe_done  out  1  to PE
- pe_w_we  out  1  to PE
- pe_x_we  out  1  to PE
- pe_out  in  PE_OUT_WIDTH  PE result
- pe_out_vd  in  1  PE result valid
- m_valid  out  1  tagged result valid (1-cycle pulse)
- m_data  out  PE_OUT_WIDTH  result
- m_tag  out  NODE_W-1  node index of the result
- busy  out  1  state != IDLE
- run_done  out  1  1-cycle completion pulse
- err  out  1  sticky flag; cleared by reset or accepted start

Behaviour:
- Reset: all outputs are registered and reset to 0. State returns to IDLE and all counters clear.
  - Reset mid-run aborts immediately. No further pe_w_we/pe_x_we are issued.
- States: IDLE -> WLOAD -> FEAT -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 with num_nodes in 1..NUM_NODES: latch num_nodes, clear err, go to WLOAD.
  - start with num_nodes=0 or num_nodes>NUM_NODES: set err, stay in IDLE, no pulse.
- WLOAD:
  - w_ready=1.
  - Each accepted beat (w_valid&w_ready) produces, one cycle later:
    - pe_w_we=1
    - pe_data_bus=w_data
    - pe_addr_bus = beat index (0..7) in bits [WGT_INDEX-1:0], other bits 0
  - After beat 7 is accepted: go to FEAT. w_ready drops the same cycle.
- FEAT:
  - s_ready=1 when outstanding<MAX_OUTST and gap counter=0.
  - Accepted beat produces, next cycle:
    - pe_x_we=1
    - data, address and nnz registered onto pe_*
    - pe_acc=0 on the first beat of a node, 1 on later beats
    - pe_done=s_last
  - Gap counter loads ISSUE_GAP-1 on accept.
  - s_last accept: nodes_issued++ and outstanding++.
  - When nodes_issued reaches num_nodes: go to DRAIN with s_ready=0.
- pe_out_vd (any non-IDLE state):
  - Next cycle: m_valid=1, m_data=pe_out, m_tag=results count; then results++ and outstanding--.
  - Same cycle as a last-beat accept: outstanding is unchanged.
- pe_out_vd in IDLE, or with outstanding=0: sets err; m_valid is not asserted.
- DRAIN: when results == num_nodes, go to FIN.
- FIN: run_done=1 for one cycle, then go to IDLE. start in FIN is ignored.
- pe_w_we and pe_x_we are never asserted in the same cycle.
- When pe_x_we=0, pe_acc and pe_done are 0.
- s_nnz>MAC_DIM: forwarded unchanged and sets err.

Decomposition:
- Shared package pe6_pkg holds:
  - ADDR_WIDTH, WGT_INDEX, BUS_W, WGT_BEATS, NODE_W
  - state encoding IDLE/WLOAD/FEAT/DRAIN/FIN
- One natural sub-module: pe_credit_cnt. It holds the outstanding counter, the MAX_OUTST compare and the simultaneous inc/dec handling.

Test Plan:
- Weight load:
  - Stimulus: start, num_nodes=1, 8 back-to-back w beats with w_data=k*0x0101...
  - Response: pe_w_we high 8 cycles, pe_addr_bus low bits 0..7, data matches beat k.
- Multi-beat node:
  - Stimulus: 3 beats with s_last only on beat 3.
  - Response: pe_acc=0,1,1; pe_done=0,0,1.
  - Stimulus: then pe_out_vd with pe_out=0x5A.
  - Response: m_valid, m_data=0x5A, m_tag=0, run_done pulse 2 cycles later.
- Credit throttle:
  - Stimulus: MAX_OUTST=2, num_nodes=4, single-beat nodes, no pe_out_vd.
  - Response: s_ready low after 2 nodes. One pe_out_vd re-enables exactly one further node.
- Simultaneous events:
  - Stimulus: last-beat accept in the same cycle as pe_out_vd with outstanding=1.
  - Response: outstanding stays 1; tags stay sequential.
- Abort:
  - Stimulus: reset asserted during FEAT after 2 of 5 nodes, then released.
  - Response: all outputs 0, busy=0. A new start runs 3 nodes correctly with tags 0..2.
- Errors:
  - Stimulus: start with num_nodes=0.
  - Response: err=1, busy stays 0.
  - Stimulus: spurious pe_out_vd in IDLE.
  - Response: err=1, no m_valid.

Source files
------------

// File: rtl/pe6_pkg.sv
// Shared constants and state encoding for the 6-MAC PE sequencer.
//   - User parameters: MAC_DIM, FEAT_WIDTH, WGT_WIDTH, SPAD_WIDTH, PE_OUT_WIDTH,
//     NUM_NODES, MAX_OUTST, ISSUE_GAP
//   - Derived widths: ADDR_WIDTH, WGT_INDEX, BUS_W, WGT_BEATS, NODE_W, AB_W,
//     CNT_W, GAP_W
//   - pe6_state_e: sequencer state encoding
package pe6_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int C_LOG_2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int MAC_DIM      = 6;
  localparam int FEAT_WIDTH   = 1;
  localparam int WGT_WIDTH    = 8;
  localparam int SPAD_WIDTH   = 64;
  localparam int PE_OUT_WIDTH = 8;
  localparam int NUM_NODES    = 20;
  localparam int MAX_OUTST    = 2;
  localparam int ISSUE_GAP    = 1;

  localparam int ADDR_WIDTH = C_LOG_2(SPAD_WIDTH);
  localparam int WGT_INDEX  = C_LOG_2(WGT_WIDTH);
  localparam int BUS_W      = FEAT_WIDTH * SPAD_WIDTH;
  localparam int WGT_BEATS  = SPAD_WIDTH * WGT_WIDTH / BUS_W;
  localparam int NODE_W     = C_LOG_2(NUM_NODES) + 1;
  localparam int AB_W       = ADDR_WIDTH * MAC_DIM;
  // Outstanding counter holds up to 7.
  localparam int CNT_W      = 3;
  localparam int GAP_W      = C_LOG_2(ISSUE_GAP) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WLOAD = 3'd1,
    S_FEAT  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } pe6_state_e;

endpackage

// File: rtl/pe_credit_cnt.sv
// Outstanding-node credit counter.
//   clk, reset  : clock, async active-low reset
//   clr_i       : synchronous clear (new run)
//   inc_i       : a node was fully issued to the PE
//   dec_i       : a PE result came back (caller guarantees cnt_o != 0)
//   cnt_o       : nodes issued but not yet returned
//   avail_o     : another node may be issued (cnt_o < MAX_OUTST)
//   zero_o      : nothing outstanding
module pe_credit_cnt
  import pe6_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             avail_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous issue and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (inc_i && !dec_i) cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign avail_o = (cnt_q < CNT_W'(MAX_OUTST));
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/pe_seq_ctrl_6.sv
// Sequencer in front of one PE_TOP_6: loads the weight scratchpad with
// WGT_BEATS beats, then streams sparse feature beats node by node, throttled
// by outstanding PE results; returned results are tagged with a node index.
//   clk, reset           : clock, async active-low reset
//   start, num_nodes     : run request (IDLE only) and node count
//   w_valid/w_ready/w_data                       : weight stream
//   s_valid/s_ready/s_data/s_addr/s_nnz/s_last   : feature stream
//   pe_*                 : drive the PE (registered, one cycle after accept)
//   pe_out, pe_out_vd    : PE result
//   m_valid/m_data/m_tag : tagged result (1-cycle pulse)
//   busy, run_done, err  : status; err is sticky until reset or accepted start
//   dbg_state, dbg_outst : current state and outstanding-node count
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; ready never depends combinationally on valid, and a producer holds its
// payload stable while valid is high and ready is low.
module pe_seq_ctrl_6
  import pe6_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NODE_W-1:0]       num_nodes,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [BUS_W-1:0]        w_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [BUS_W-1:0]        s_data,
  input  logic [AB_W-1:0]         s_addr,
  input  logic [2:0]              s_nnz,
  input  logic                    s_last,
  output logic [AB_W-1:0]         pe_addr_bus,
  output logic [BUS_W-1:0]        pe_data_bus,
  output logic [2:0]              pe_non_zero_num,
  output logic                    pe_acc,
  output logic                    pe_done,
  output logic                    pe_w_we,
  output logic                    pe_x_we,
  input  logic [PE_OUT_WIDTH-1:0] pe_out,
  input  logic                    pe_out_vd,
  output logic                    m_valid,
  output logic [PE_OUT_WIDTH-1:0] m_data,
  output logic [NODE_W-2:0]       m_tag,
  output logic                    busy,
  output logic                    run_done,
  output logic                    err,
  output logic [2:0]              dbg_state,
  output logic [CNT_W-1:0]        dbg_outst
);

  pe6_state_e               state_q;
  logic [NODE_W-1:0]        num_q, issued_q, results_q;
  logic [WGT_INDEX-1:0]     w_beat_q;
  logic [GAP_W-1:0]         gap_q;
  logic                     first_q;

  logic                     credit_avail, credit_zero;
  logic                     w_acc, s_acc, res_ok, start_ok;

  assign w_ready  = (state_q == S_WLOAD);
  assign s_ready  = (state_q == S_FEAT) && credit_avail && (gap_q == '0);
  assign w_acc    = w_valid && w_ready;
  assign s_acc    = s_valid && s_ready;
  // A result is only legal while a node is actually outstanding.
  assign res_ok   = pe_out_vd && (state_q != S_IDLE) && !credit_zero;
  assign start_ok = (state_q == S_IDLE) && start && (num_nodes != '0) &&
                    (num_nodes <= NODE_W'(NUM_NODES));

  pe_credit_cnt u_credit (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (start_ok),
    .inc_i   (s_acc && s_last),
    .dec_i   (res_ok),
    .cnt_o   (dbg_outst),
    .avail_o (credit_avail),
    .zero_o  (credit_zero)
  );

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      num_q           <= '0;
      issued_q        <= '0;
      results_q       <= '0;
      w_beat_q        <= '0;
      gap_q           <= '0;
      first_q         <= 1'b0;
      pe_addr_bus     <= '0;
      pe_data_bus     <= '0;
      pe_non_zero_num <= '0;
      pe_acc          <= 1'b0;
      pe_done         <= 1'b0;
      pe_w_we         <= 1'b0;
      pe_x_we         <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_tag           <= '0;
      run_done        <= 1'b0;
      err             <= 1'b0;
    end else begin
      // Strobes default low; pe_acc/pe_done only ever ride with pe_x_we.
      pe_w_we  <= 1'b0;
      pe_x_we  <= 1'b0;
      pe_acc   <= 1'b0;
      pe_done  <= 1'b0;
      m_valid  <= 1'b0;
      run_done <= 1'b0;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            num_q     <= num_nodes;
            issued_q  <= '0;
            results_q <= '0;
            w_beat_q  <= '0;
            gap_q     <= '0;
            first_q   <= 1'b1;
            err       <= 1'b0;
            state_q   <= S_WLOAD;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        S_WLOAD: begin
          if (w_acc) begin
            pe_w_we     <= 1'b1;
            pe_data_bus <= w_data;
            pe_addr_bus <= AB_W'(w_beat_q);
            w_beat_q    <= w_beat_q + 1'b1;
            if (w_beat_q == WGT_INDEX'(WGT_BEATS - 1)) state_q <= S_FEAT;
          end
        end
        S_FEAT: begin
          if (s_acc) begin
            pe_x_we         <= 1'b1;
            pe_data_bus     <= s_data;
            pe_addr_bus     <= s_addr;
            pe_non_zero_num <= s_nnz;
            pe_acc          <= !first_q;
            pe_done         <= s_last;
            gap_q           <= GAP_W'(ISSUE_GAP - 1);
            if (s_nnz > 3'(MAC_DIM)) err <= 1'b1;
            first_q <= s_last;
            if (s_last) begin
              issued_q <= issued_q + 1'b1;
              if (issued_q + 1'b1 == num_q) state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (results_q == num_q) begin
            state_q  <= S_FIN;
            run_done <= 1'b1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      // Result path runs in every state; placed last so an error set here
      // wins over the err clear of a same-cycle accepted start.
      if (res_ok) begin
        m_valid   <= 1'b1;
        m_data    <= pe_out;
        m_tag     <= results_q[NODE_W-2:0];
        results_q <= results_q + 1'b1;
      end else if (pe_out_vd) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl_6.sv
module tb_pe_seq_ctrl_6;
  import pe6_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [NODE_W-1:0]       num_nodes;
  logic                    w_valid, w_ready;
  logic [BUS_W-1:0]        w_data;
  logic                    s_valid, s_ready;
  logic [BUS_W-1:0]        s_data;
  logic [AB_W-1:0]         s_addr;
  logic [2:0]              s_nnz;
  logic                    s_last;
  logic [AB_W-1:0]         pe_addr_bus;
  logic [BUS_W-1:0]        pe_data_bus;
  logic [2:0]              pe_non_zero_num;
  logic                    pe_acc, pe_done, pe_w_we, pe_x_we;
  logic [PE_OUT_WIDTH-1:0] pe_out;
  logic                    pe_out_vd;
  logic                    m_valid;
  logic [PE_OUT_WIDTH-1:0] m_data;
  logic [NODE_W-2:0]       m_tag;
  logic                    busy, run_done, err;
  logic [2:0]              dbg_state;
  logic [CNT_W-1:0]        dbg_outst;

  int n_checks = 0;
  int n_errors = 0;

  pe_seq_ctrl_6 dut (
    .clk(clk), .reset(reset), .start(start), .num_nodes(num_nodes),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr),
    .s_nnz(s_nnz), .s_last(s_last),
    .pe_addr_bus(pe_addr_bus), .pe_data_bus(pe_data_bus),
    .pe_non_zero_num(pe_non_zero_num), .pe_acc(pe_acc), .pe_done(pe_done),
    .pe_w_we(pe_w_we), .pe_x_we(pe_x_we), .pe_out(pe_out), .pe_out_vd(pe_out_vd),
    .m_valid(m_valid), .m_data(m_data), .m_tag(m_tag), .busy(busy),
    .run_done(run_done), .err(err), .dbg_state(dbg_state), .dbg_outst(dbg_outst)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge, outputs are
  // sampled at the same point (they reflect the edge just taken).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    num_nodes = NODE_W'(n);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic load_weights();
    for (int k = 0; k < WGT_BEATS; k++) begin
      w_valid = 1'b1;
      w_data  = 64'(k) * 64'h0101_0101_0101_0101;
      step();
      check_eq("wload_w_we", pe_w_we, 1);
      check_eq("wload_x_we", pe_x_we, 0);
      check_eq("wload_data", pe_data_bus, 64'(k) * 64'h0101_0101_0101_0101);
      check_eq("wload_addr", pe_addr_bus, 64'(k));
    end
    w_valid = 1'b0;
    check_eq("wload_ready_drop", w_ready, 0);
    check_eq("wload_to_feat", dbg_state, S_FEAT);
    check_eq("feat_s_ready", s_ready, 1);
  endtask

  task automatic drive_node_beat(input logic last, input int seed);
    s_valid = 1'b1;
    s_last  = last;
    s_nnz   = 3'd1;
    s_data  = 64'hC0DE_0000_0000_0000 | 64'(seed);
    s_addr  = AB_W'(seed);
  endtask

  task automatic return_result(input logic [7:0] val);
    pe_out_vd = 1'b1;
    pe_out    = val;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_nodes = '0;
    w_valid = 1'b0; w_data = '0;
    s_valid = 1'b0; s_data = '0; s_addr = '0; s_nnz = '0; s_last = 1'b0;
    pe_out = '0; pe_out_vd = 1'b0;
    repeat (3) step();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_w_we", pe_w_we, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ready", {w_ready, s_ready}, 0);
    reset = 1'b1;
    step();

    // ---- weight load + multi-beat node ----
    do_start(1);
    check_eq("start_busy", busy, 1);
    check_eq("start_w_ready", w_ready, 1);
    load_weights();
    for (int j = 0; j < 3; j++) begin
      check_eq("mb_s_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = 64'hF0F0_0000_0000_0000 | 64'(j);
      s_addr  = AB_W'(j * 7 + 1);
      s_nnz   = 3'(j + 1);
      s_last  = (j == 2);
      step();
      check_eq("mb_x_we", pe_x_we, 1);
      check_eq("mb_acc", pe_acc, (j != 0));
      check_eq("mb_done", pe_done, (j == 2));
      check_eq("mb_nnz", pe_non_zero_num, 64'(j + 1));
      check_eq("mb_addr", pe_addr_bus, 64'(j * 7 + 1));
      check_eq("mb_data", pe_data_bus, 64'hF0F0_0000_0000_0000 | 64'(j));
    end
    s_valid = 1'b0; s_last = 1'b0;
    check_eq("mb_drain_state", dbg_state, S_DRAIN);
    check_eq("mb_drain_s_ready", s_ready, 0);
    check_eq("mb_outst", dbg_outst, 1);
    return_result(8'h5A);
    step();
    pe_out_vd = 1'b0;
    check_eq("mb_m_valid", m_valid, 1);
    check_eq("mb_m_data", m_data, 8'h5A);
    check_eq("mb_m_tag", m_tag, 0);
    check_eq("mb_run_done_early", run_done, 0);
    step();
    check_eq("mb_m_valid_pulse", m_valid, 0);
    check_eq("mb_run_done", run_done, 1);
    step();
    check_eq("mb_run_done_pulse", run_done, 0);
    check_eq("mb_idle", busy, 0);
    check_eq("mb_err", err, 0);

    // ---- credit throttle + simultaneous events ----
    do_start(4);
    load_weights();
    drive_node_beat(1'b1, 1);
    step();
    check_eq("cr_x_we0", pe_x_we, 1);
    check_eq("cr_done0", pe_done, 1);
    check_eq("cr_acc0", pe_acc, 0);
    check_eq("cr_ready_1out", s_ready, 1);
    drive_node_beat(1'b1, 2);
    step();
    check_eq("cr_x_we1", pe_x_we, 1);
    check_eq("cr_acc1", pe_acc, 0);
    check_eq("cr_ready_full", s_ready, 0);
    check_eq("cr_outst2", dbg_outst, 2);
    step();
    check_eq("cr_no_issue", pe_x_we, 0);
    check_eq("cr_still_blocked", s_ready, 0);
    return_result(8'h11);
    step();
    pe_out_vd = 1'b0;
    check_eq("cr_m_tag0", m_tag, 0);
    check_eq("cr_m_data0", m_data, 8'h11);
    check_eq("cr_reopen", s_ready, 1);
    check_eq("cr_outst1", dbg_outst, 1);
    drive_node_beat(1'b1, 3);
    step();
    check_eq("cr_one_more", pe_x_we, 1);
    check_eq("cr_blocked_again", s_ready, 0);
    step();
    check_eq("cr_no_issue2", pe_x_we, 0);
    return_result(8'h22);
    step();
    check_eq("cr_m_tag1", m_tag, 1);
    check_eq("cr_outst_1b", dbg_outst, 1);
    check_eq("cr_reopen2", s_ready, 1);
    // Last-beat accept and a result in the same cycle with one outstanding.
    drive_node_beat(1'b1, 4);
    return_result(8'h33);
    step();
    check_eq("sim_x_we", pe_x_we, 1);
    check_eq("sim_m_valid", m_valid, 1);
    check_eq("sim_m_tag2", m_tag, 2);
    check_eq("sim_m_data", m_data, 8'h33);
    check_eq("sim_outst_held", dbg_outst, 1);
    check_eq("sim_drain", dbg_state, S_DRAIN);
    s_valid = 1'b0;
    return_result(8'h44);
    step();
    pe_out_vd = 1'b0;
    check_eq("sim_m_tag3", m_tag, 3);
    check_eq("sim_outst0", dbg_outst, 0);
    step();
    check_eq("sim_run_done", run_done, 1);
    step();
    check_eq("sim_idle", busy, 0);
    check_eq("sim_err", err, 0);

    // ---- abort mid-run ----
    do_start(5);
    load_weights();
    drive_node_beat(1'b1, 5);
    step();
    drive_node_beat(1'b1, 6);
    step();
    check_eq("ab_outst2", dbg_outst, 2);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("ab_busy", busy, 0);
    check_eq("ab_x_we", pe_x_we, 0);
    check_eq("ab_outputs", {pe_w_we, pe_acc, pe_done, m_valid, run_done, err}, 0);
    check_eq("ab_buses", pe_data_bus | 64'(pe_addr_bus), 0);
    check_eq("ab_outst", dbg_outst, 0);
    repeat (2) step();
    check_eq("ab_quiet", {pe_w_we, pe_x_we}, 0);
    reset = 1'b1;
    step();
    do_start(3);
    load_weights();
    for (int i = 0; i < 3; i++) begin
      drive_node_beat(1'b1, 8 + i);
      step();
      s_valid = 1'b0;
      check_eq("ab2_x_we", pe_x_we, 1);
      return_result(8'(8'h60 + i));
      step();
      pe_out_vd = 1'b0;
      check_eq("ab2_m_valid", m_valid, 1);
      check_eq("ab2_m_tag", m_tag, 64'(i));
      check_eq("ab2_m_data", m_data, 64'(8'h60 + i));
    end
    step();
    check_eq("ab2_run_done", run_done, 1);
    step();
    check_eq("ab2_idle", busy, 0);
    check_eq("ab2_err", err, 0);

    // ---- error cases ----
    return_result(8'h77);
    step();
    pe_out_vd = 1'b0;
    check_eq("err_spurious_m_valid", m_valid, 0);
    check_eq("err_spurious", err, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("err_cleared_by_reset", err, 0);
    step();
    do_start(0);
    check_eq("err_num0", err, 1);
    check_eq("err_num0_busy", busy, 0);
    do_start(21);
    check_eq("err_num21", err, 1);
    check_eq("err_num21_busy", busy, 0);
    do_start(20);
    check_eq("err_clear_on_start", err, 0);
    check_eq("err_start_busy", busy, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
